enc4to2_q: RTL and testbench
============================

Name: enc4to2_q

Overview:
- Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 decoder with enable.
- Captures one-hot or multi-hot request lines into a pending register.
- Emits one binary index per accepted transfer on a valid/ready output, then clears that request.
- Sits between request sources (interrupt or event lines) and a consumer of encoded indices.

Parameters:
- N, 4, number of request lines; must equal 2**W.
- W, 2, width of encoded index output.

Ports:
- clk    input   1  rising-edge clock.
- rst_n  input   1  reset, synchronous, active-low.
- en     input   1  request capture enable; when 0, a is ignored.
- a      input   N  request lines, sampled every clk edge with en=1.
- rdy    input   1  consumer ready.
- s      output  W  encoded index of granted request.
- vld    output  1  s valid.
- busy   output  1  pending register non-zero.

Behaviour:
- Reset: one clock, synchronous, active-low, sampled on rising clk. While rst_n=0 at an edge: pending=0, s=0, vld=0, busy=0, grant pointer=N-1. Reset overrides all other activity, including a transfer in flight; a is not captured during reset.
- Capture:
  - pending_next = (pending & ~grant_mask) | (en ? a : 0).
  - New set wins over same-cycle clear: a bit re-requested in its own grant cycle stays pending.
  - Requests OR-merge: repeated requests on an already pending bit collapse to one.
- Output register load condition: load = !vld || rdy.
  - On load with pending != 0: s <= selected index; vld <= 1; grant_mask = onehot(selected); otherwise grant_mask = 0.
  - On load with pending == 0: vld <= 0; s holds its last value.
  - No load (vld && !rdy): s and vld held stable; pending keeps accumulating.
- Selection uses the registered pending only; requests captured this edge are not eligible until the next edge.
- Default selection is fixed priority: the highest set index wins (bit N-1 highest).
- Latency: request present at edge E0 (en=1) -> pending after E0 -> vld=1 with s valid after E1, if rdy permits. Throughput is one index per cycle with rdy=1.
- busy = |pending (registered, from pending).
- en=0 does not stop the drain; pending empties normally.
- a=0 with en=1 has no effect.
- All ones: N transfers, one per accepted cycle.

Optional Feature:
- Macro: ENC4TO2_RR_EN.
- Defined: round-robin selection.
  - Search starts at (ptr+1) mod N, incrementing and wrapping; the first pending bit wins.
  - ptr <= selected index on each load that grants.
  - ptr resets to N-1, so the first search starts at bit 0.
- Undefined: fixed highest-index priority; no pointer register is built.

Test Plan:
- Reset: rst_n=0 for 2 cycles, en=1, a=4'hF -> vld=0, s=0, busy=0 during reset and on the first cycle after release.
- Single: en=1, a=4'b0100 for one cycle, rdy=1 -> vld=1 with s=2 for exactly one cycle, starting 2 edges after capture; busy=0 afterwards.
- Priority/drain:
  - a=4'b1011 for one cycle, rdy=1, fixed priority -> s=3,1,0 on consecutive cycles, vld high for exactly 3 cycles.
  - Same stimulus with ENC4TO2_RR_EN -> s=0,1,3.
- Backpressure:
  - a=4'b0110, rdy=0 for 5 cycles -> s=2, vld=1 held stable, busy=1.
  - Then rdy=1 -> s=1 next cycle, then vld=0.
- en gating: en=0, a=4'hF for 4 cycles -> vld=0, busy=0 throughout.
- Re-request and reset mid-operation:
  - a=4'b0001 held with en=1 for 3 cycles, rdy=1 -> s=0, vld=1 continuously, plus one trailing cycle.
  - a=4'hF, rdy=0, then rst_n=0 for 1 cycle -> vld=0, busy=0 immediately after that edge.

Source files
------------

// File: rtl/enc4to2_q.sv
// enc4to2_q: sequential 4-to-2 request encoder with valid/ready output.
// Request lines are OR-merged into a pending register. One encoded index
// is issued per accepted transfer, and the granted request is then cleared.
// Optional macro ENC4TO2_RR_EN selects round-robin arbitration.
// Without it, the highest pending index always wins.
module enc4to2_q #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] a,
    input  logic         rdy,
    output logic [W-1:0] s,
    output logic         vld,
    output logic         busy
);

    logic [N-1:0] pending;
    logic [N-1:0] pending_next;
    logic [N-1:0] grant_mask;
    logic [W-1:0] sel;
    logic         load;
    logic         grant;
    logic [W-1:0] s_next;
    logic         vld_next;

`ifdef ENC4TO2_RR_EN
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;

    // Round-robin pick: search upward from the slot after the last grant, wrapping.
    always_comb begin
        logic         found;
        logic [W-1:0] idx;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= int'(N); i++) begin
            idx = ptr + W'(i);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`else
    // Fixed priority pick: the highest set index wins, because later iterations overwrite earlier ones.
    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (pending[i]) begin
                sel = W'(i);
            end
        end
    end
`endif

    // Next-state logic for the output slot and the pending register.
    always_comb begin
        load         = !vld || rdy;
        grant        = load && (pending != '0);
        grant_mask   = '0;
        s_next       = s;
        vld_next     = vld;
        if (load) begin
            vld_next = grant;
            if (grant) begin
                s_next     = sel;
                grant_mask = N'(1) << sel;
            end
        end
        // A new request set wins over the same-cycle clear of a granted bit.
        pending_next = (pending & ~grant_mask) | (en ? a : '0);
    end

`ifdef ENC4TO2_RR_EN
    // Move the pointer to the most recently granted index.
    always_comb begin
        ptr_next = ptr;
        if (grant) begin
            ptr_next = sel;
        end
    end

    // Round-robin pointer register; after reset the search starts at bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else begin
            ptr <= ptr_next;
        end
    end
`endif

    // State and output registers; busy tracks whether pending is non-zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            s       <= '0;
            vld     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            pending <= pending_next;
            s       <= s_next;
            vld     <= vld_next;
            busy    <= |pending_next;
        end
    end

endmodule

// File: tb/tb_enc4to2_q.sv
// Self-checking bench for enc4to2_q.
// The expected values are worked out by hand for the default build.
// Where ENC4TO2_RR_EN changes the arbitration result, the round-robin values are used instead.
module tb_enc4to2_q;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;
`ifdef ENC4TO2_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic         rst_n;
        logic         en;
        logic [N-1:0] a;
        logic         rdy;
        logic [W-1:0] exp_s;
        logic         exp_vld;
        logic         exp_busy;
        string        name;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [N-1:0] a;
    logic         rdy;
    logic [W-1:0] s;
    logic         vld;
    logic         busy;

    int checks = 0;
    int passed = 0;

    enc4to2_q #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .rdy   (rdy),
        .s     (s),
        .vld   (vld),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it, then check the outputs on the falling edge.
    task automatic step(input logic r, input logic e, input logic [N-1:0] av, input logic rd,
                        input logic [W-1:0] es, input logic ev, input logic eb, input string nm);
        rst_n = r;
        en    = e;
        a     = av;
        rdy   = rd;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s === es && vld === ev && busy === eb) begin
            passed++;
        end else begin
            $display("FAIL %s: got s=%0d vld=%0b busy=%0b, expected s=%0d vld=%0b busy=%0b",
                     nm, s, vld, busy, es, ev, eb);
        end
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        a     = 4'hF;
        rdy   = 1'b1;

        // Reset with active requests, then return to idle.
        vecs.push_back('{1'b0, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, "reset0"});
        vecs.push_back('{1'b0, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, "reset1"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0, "post_reset"});
        // Priority and drain order for 1011.
        vecs.push_back('{1'b1, 1'b1, 4'b1011, 1'b1, 2'd0, 1'b0, 1'b1, "prio_cap"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, RR ? 2'd0 : 2'd3, 1'b1, 1'b1, "prio_g0"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1, 1'b1, "prio_g1"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, RR ? 2'd3 : 2'd0, 1'b1, 1'b0, "prio_g2"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, RR ? 2'd3 : 2'd0, 1'b0, 1'b0, "prio_end"});
        // Single request: s holds its last value until the grant arrives.
        vecs.push_back('{1'b1, 1'b1, 4'b0100, 1'b1, RR ? 2'd3 : 2'd0, 1'b0, 1'b1, "single_cap"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 1'b0, "single_g"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 1'b0, "single_end"});
        // en gating: requests are ignored while en is low.
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b1, 1'b0, 4'hF, 1'b1, 2'd2, 1'b0, 1'b0, "en_gate"});
        // Re-request held for three cycles: vld stays high throughout, plus one trailing cycle.
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b0, 1'b1, "rereq0"});
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, "rereq1"});
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, "rereq2"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, "rereq3"});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0, "rereq_end"});

        foreach (vecs[i])
            step(vecs[i].rst_n, vecs[i].en, vecs[i].a, vecs[i].rdy,
                 vecs[i].exp_s, vecs[i].exp_vld, vecs[i].exp_busy, vecs[i].name);

        // Backpressure: the output is held stable while rdy is low.
        step(1'b1, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b0, 1'b1, "bp_cap");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 4'h0, 1'b0, RR ? 2'd1 : 2'd2, 1'b1, 1'b1, "bp_hold");
        step(1'b1, 1'b0, 4'h0, 1'b1, RR ? 2'd2 : 2'd1, 1'b1, 1'b0, "bp_release");
        step(1'b1, 1'b0, 4'h0, 1'b1, RR ? 2'd2 : 2'd1, 1'b0, 1'b0, "bp_end");

        // Reset while a transfer is in flight.
        step(1'b1, 1'b1, 4'hF, 1'b0, RR ? 2'd2 : 2'd1, 1'b0, 1'b1, "mid_cap");
        step(1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 1'b1, 1'b1, "mid_grant");
        step(1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0, "mid_reset");
        step(1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0, "mid_after");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
